// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: constants and types shared by the instruction fetch unit.
//   PC_default - reset/base PC, word 0 of instruction memory
//   INSTR_NOP  - instruction encoding substituted for bad-address fetches
//   fetch_entry_t - one queued {pc, instr} pair (64 bits)
package ifu_fetch_pkg;

   localparam logic [31:0] PC_default = 32'h0000_3000;
   localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle of the signals between the fetch unit, the PC register,
// the instruction memory and decode.
//   master - fetch unit side (drives pc_en, im_addr, id_*, fetch_err)
//   slave  - environment side (drives pc_in, im_rdata, flush, id_ready)
interface ifu_fetch_if #(
   parameter int IM_AW = 12
);
   logic [31:0]      pc_in;
   logic             pc_en;
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      im_rdata;
   logic             flush;
   logic             id_valid;
   logic [31:0]      id_instr;
   logic [31:0]      id_pc;
   logic [31:0]      id_pc8;
   logic             id_ready;
   logic             fetch_err;

   modport master (
      input  pc_in, im_rdata, flush, id_ready,
      output pc_en, im_addr, id_valid, id_instr, id_pc, id_pc8, fetch_err
   );

   modport slave (
      output pc_in, im_rdata, flush, id_ready,
      input  pc_en, im_addr, id_valid, id_instr, id_pc, id_pc8, fetch_err
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// ifu_queue: DEPTH-entry FIFO of W-bit words with synchronous active-high reset.
// Ports:
//   clk, reset       - clock, synchronous reset (storage reloads RST_DATA)
//   push, push_data  - write at the tail (ignored when full)
//   pop              - advance the head (ignored when empty)
//   flush            - drop all entries; wins over push and pop
//   count            - number of valid entries
//   head             - entry at the head pointer
//   full, empty      - occupancy flags
module ifu_queue #(
   parameter int             DEPTH    = 2,
   parameter int             W        = 64,
   parameter logic [W-1:0]   RST_DATA = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [PW-1:0] tail_ptr_q, tail_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      do_push = push & !full;
      do_pop  = pop & !empty;

      mem_d      = mem_q;
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      count_d    = count_q;

      if (flush) begin
         head_ptr_d = '0;
         tail_ptr_d = '0;
         count_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[tail_ptr_q] = push_data;
            tail_ptr_d        = ptr_inc(tail_ptr_q);
         end
         if (do_pop) begin
            head_ptr_d = ptr_inc(head_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RST_DATA;
         end
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         count_q    <= '0;
      end else begin
         mem_q      <= mem_d;
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         count_q    <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[head_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit between the PC register and decode.
// Issues pc_in to a synchronous-read instruction memory, captures the word a
// cycle later and queues {pc, instr} pairs for decode (valid/ready).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   bus (master)    - pc_in/pc_en to the PC register, im_addr/im_rdata to
//                     instruction memory, flush from decode, id_* to decode,
//                     fetch_err sticky bad-address flag
// Build option:
//   IFU_ADDR_CHECK_EN - flag misaligned/out-of-range PCs, substitute a nop and
//                       set fetch_err; when undefined fetch_err is tied to 0.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] PC_BASE = PC_default,
   parameter int          IM_AW   = 12,
   parameter int          DEPTH   = 2
) (
   input logic         clk,
   input logic         reset,
   ifu_fetch_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [31:0]   pc_off;
   logic          pop, push, issue;
   logic [OW-1:0] occupancy;
   logic [CW-1:0] q_count;
   logic          q_full, q_empty;
   fetch_entry_t  push_entry, head_entry;

   // Occupancy counts the in-flight word as already owning a slot, so an issue
   // is only made when the returning word is guaranteed room next cycle.
   always_comb begin
      pc_off    = bus.pc_in - PC_BASE;
      pop       = !q_empty & bus.id_ready;
      occupancy = OW'(q_count) + OW'(inflight_q) - OW'(pop);
      issue     = !reset & !bus.flush & (occupancy < OW'(DEPTH));
      push      = inflight_q & !bus.flush & !q_full;
   end

   always_comb begin
      inflight_d    = issue;
      inflight_pc_d = issue ? bus.pc_in : inflight_pc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q    <= 1'b0;
         inflight_pc_q <= PC_BASE;
      end else begin
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // A flush still loads the PC so the redirect target is taken this cycle.
   assign bus.pc_en   = issue | (bus.flush & !reset);
   assign bus.im_addr = IM_AW'(pc_off >> 2);

`ifdef IFU_ADDR_CHECK_EN
   logic addr_bad;
   logic inflight_bad_q, inflight_bad_d;
   logic fetch_err_q, fetch_err_d;

   always_comb begin
      addr_bad = (bus.pc_in[1:0] != 2'b00) |
                 (bus.pc_in < PC_BASE) |
                 ((pc_off >> (IM_AW + 2)) != 32'd0);
      inflight_bad_d = issue & addr_bad;
      fetch_err_d    = fetch_err_q | (push & inflight_bad_q);
      push_entry.pc    = inflight_pc_q;
      push_entry.instr = inflight_bad_q ? INSTR_NOP : bus.im_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_bad_q <= 1'b0;
         fetch_err_q    <= 1'b0;
      end else begin
         inflight_bad_q <= inflight_bad_d;
         fetch_err_q    <= fetch_err_d;
      end
   end

   assign bus.fetch_err = fetch_err_q;
`else
   always_comb begin
      push_entry.pc    = inflight_pc_q;
      push_entry.instr = bus.im_rdata;
   end

   assign bus.fetch_err = 1'b0;
`endif

   ifu_queue #(
      .DEPTH    (DEPTH),
      .W        (64),
      .RST_DATA ({PC_BASE, INSTR_NOP})
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (bus.flush),
      .count     (q_count),
      .head      (head_entry),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign bus.id_valid = !q_empty;
   assign bus.id_instr = head_entry.instr;
   assign bus.id_pc    = head_entry.pc;
   assign bus.id_pc8   = head_entry.pc + 32'd8;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a PC register model and a
// synchronous-read memory whose word k holds 32'h1000_0000 + k.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam logic [31:0] WORD0 = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] redirect_pc;
   int          errors = 0;
   int          checks = 0;
   int          exp_k;

   ifu_fetch_if #(.IM_AW(12)) bus ();

   ifu_fetch #(
      .PC_BASE (BASE),
      .IM_AW   (12),
      .DEPTH   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // PC register and instruction memory models
   always @(posedge clk) begin
      if (reset) bus.pc_in <= BASE;
      else if (bus.pc_en) bus.pc_in <= bus.flush ? redirect_pc : bus.pc_in + 32'd4;
      bus.im_rdata <= WORD0 + {20'h0, bus.im_addr};
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.id_ready = 1'b1;
      redirect_pc = BASE;
      repeat (3) next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
      checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.id_instr); end
      checks++; if (bus.id_pc !== BASE) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.id_pc, BASE); end
      checks++; if (bus.id_pc8 !== BASE + 32'd8) begin errors++; $display("FAIL reset_pc8: got %h expected %h", bus.id_pc8, BASE + 32'd8); end
      checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b expected 0", bus.pc_en); end
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b expected 0", bus.fetch_err); end
   endtask

   task automatic test_stream;
      next_cycle();
      reset = 1'b0;
      mid();
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL stream_first_pc_en: got %b expected 1", bus.pc_en); end
      checks++; if (bus.im_addr !== 12'h000) begin errors++; $display("FAIL stream_first_addr: got %h expected 000", bus.im_addr); end
      next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got %b expected 0", bus.id_valid); end
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         mid();
         checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.id_valid); end
         checks++; if (bus.id_pc !== BASE + 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bus.id_pc, BASE + 32'(4 * k)); end
         checks++; if (bus.id_instr !== WORD0 + 32'(k)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, bus.id_instr, WORD0 + 32'(k)); end
         checks++; if (bus.id_pc8 !== BASE + 32'(4 * k + 8)) begin errors++; $display("FAIL stream_pc8[%0d]: got %h expected %h", k, bus.id_pc8, BASE + 32'(4 * k + 8)); end
      end
      exp_k = 6;
   endtask

   task automatic test_stall;
      next_cycle();
      bus.id_ready = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         if (s > 1) next_cycle();
         mid();
         checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", s, bus.id_valid); end
         checks++; if (bus.id_pc !== BASE + 32'(4 * exp_k)) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", s, bus.id_pc, BASE + 32'(4 * exp_k)); end
         checks++; if (bus.id_instr !== WORD0 + 32'(exp_k)) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", s, bus.id_instr, WORD0 + 32'(exp_k)); end
         if (s >= 3) begin
            checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL stall_pc_en[%0d]: got %b expected 0", s, bus.pc_en); end
            checks++; if (dut.q_count !== 2'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", s, dut.q_count); end
         end
      end
      next_cycle();
      bus.id_ready = 1'b1;
      mid();
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL release_pc_en: got %b expected 1", bus.pc_en); end
      checks++; if (bus.id_pc !== BASE + 32'(4 * exp_k)) begin errors++; $display("FAIL release_pc: got %h expected %h", bus.id_pc, BASE + 32'(4 * exp_k)); end
      exp_k++;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mid();
         checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL release_valid[%0d]: got %b expected 1", i, bus.id_valid); end
         checks++; if (bus.id_pc !== BASE + 32'(4 * exp_k)) begin errors++; $display("FAIL release_seq[%0d]: got %h expected %h", i, bus.id_pc, BASE + 32'(4 * exp_k)); end
         exp_k++;
      end
   endtask

   task automatic test_flush;
      next_cycle();
      bus.id_ready = 1'b0;
      bus.flush = 1'b1;
      redirect_pc = BASE + 32'h40;
      mid();
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL flush_pc_en: got %b expected 1", bus.pc_en); end
      next_cycle();
      bus.flush = 1'b0;
      bus.id_ready = 1'b1;
      mid();
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.id_valid); end
      checks++; if (bus.im_addr !== 12'h010) begin errors++; $display("FAIL flush_redirect_addr: got %h expected 010", bus.im_addr); end
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL flush_resume_pc_en: got %b expected 1", bus.pc_en); end
      next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid2: got %b expected 0", bus.id_valid); end
      next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL flush_target_valid: got %b expected 1", bus.id_valid); end
      checks++; if (bus.id_pc !== BASE + 32'h40) begin errors++; $display("FAIL flush_target_pc: got %h expected %h", bus.id_pc, BASE + 32'h40); end
      checks++; if (bus.id_instr !== WORD0 + 32'h10) begin errors++; $display("FAIL flush_target_instr: got %h expected %h", bus.id_instr, WORD0 + 32'h10); end
      exp_k = 17;
      next_cycle();
      mid();
      checks++; if (bus.id_pc !== BASE + 32'(4 * exp_k)) begin errors++; $display("FAIL flush_follow_pc: got %h expected %h", bus.id_pc, BASE + 32'(4 * exp_k)); end
      exp_k++;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         mid();
         checks++; if (dut.q_count !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, dut.q_count); end
         checks++; if (bus.id_pc !== BASE + 32'(4 * exp_k)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, bus.id_pc, BASE + 32'(4 * exp_k)); end
         checks++; if (bus.id_instr !== WORD0 + 32'(exp_k)) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, bus.id_instr, WORD0 + 32'(exp_k)); end
         exp_k++;
      end
   endtask

   task automatic test_reset_mid;
      next_cycle();
      bus.id_ready = 1'b0;
      mid();
      next_cycle();
      mid();
      checks++; if (dut.q_count !== 2'd2) begin errors++; $display("FAIL rmid_filled: got %0d expected 2", dut.q_count); end
      next_cycle();
      reset = 1'b1;
      mid();
      checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rmid_pc_en: got %b expected 0", bus.pc_en); end
      next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.id_valid); end
      checks++; if (bus.id_pc !== BASE) begin errors++; $display("FAIL rmid_pc: got %h expected %h", bus.id_pc, BASE); end
      checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rmid_pc_en2: got %b expected 0", bus.pc_en); end
      next_cycle();
      reset = 1'b0;
      bus.id_ready = 1'b1;
      mid();
      checks++; if (bus.im_addr !== 12'h000) begin errors++; $display("FAIL rmid_restart_addr: got %h expected 000", bus.im_addr); end
      next_cycle();
      next_cycle();
      mid();
      checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL rmid_restart_valid: got %b expected 1", bus.id_valid); end
      checks++; if (bus.id_pc !== BASE) begin errors++; $display("FAIL rmid_restart_pc: got %h expected %h", bus.id_pc, BASE); end
      exp_k = 1;
   endtask

   task automatic test_addr_check;
      logic [31:0] exp_instr;
      logic        exp_err;
`ifdef IFU_ADDR_CHECK_EN
      exp_instr = 32'h0;
      exp_err   = 1'b1;
`else
      exp_instr = WORD0;
      exp_err   = 1'b0;
`endif
      next_cycle();
      bus.flush = 1'b1;
      redirect_pc = BASE + 32'h2;
      mid();
      next_cycle();
      bus.flush = 1'b0;
      mid();
      checks++; if (bus.im_addr !== 12'h000) begin errors++; $display("FAIL addr_bad_im_addr: got %h expected 000", bus.im_addr); end
      next_cycle();
      mid();
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL addr_err_early: got %b expected 0", bus.fetch_err); end
      next_cycle();
      mid();
      checks++; if (bus.id_pc !== BASE + 32'h2) begin errors++; $display("FAIL addr_bad_pc: got %h expected %h", bus.id_pc, BASE + 32'h2); end
      checks++; if (bus.id_instr !== exp_instr) begin errors++; $display("FAIL addr_bad_instr: got %h expected %h", bus.id_instr, exp_instr); end
      checks++; if (bus.fetch_err !== exp_err) begin errors++; $display("FAIL addr_err_set: got %b expected %b", bus.fetch_err, exp_err); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mid();
         checks++; if (bus.fetch_err !== exp_err) begin errors++; $display("FAIL addr_err_hold[%0d]: got %b expected %b", i, bus.fetch_err, exp_err); end
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      mid();
      checks++; if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL addr_err_cleared: got %b expected 0", bus.fetch_err); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      test_back_to_back();
      test_addr_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit sitting directly downstream of the PC register and upstream of decode. Each cycle it may issue the current PC to the synchronous-read instruction memory, capture the returned word one cycle later, and buffer `{pc, instr}` pairs in a small queue that decode drains with a valid/ready handshake. It drives the PC register's enable so the PC advances only when a fetch is issued, and it squashes all buffered and in-flight fetches on a redirect flush.

## Interface
- `PC_BASE`, 32'h0000_3000: reset/base PC; word 0 of instruction memory.
- `IM_AW`, 12: instruction memory word-address width.
- `DEPTH`, 2: queue entries, minimum 2.
- `clk` input 1: single clock; everything is registered on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the `clk` rising edge.
- `pc_in` input 32: current PC register value.
- `pc_en` output 1: PC register load enable; the PC loads NPC when it is high.
- `im_addr` output IM_AW: instruction memory word address.
- `im_rdata` input 32: instruction word, valid the cycle after `im_addr` is presented.
- `flush` input 1: redirect from decode (taken branch or jump).
- `id_valid` output 1: the queue head is valid.
- `id_instr` output 32: head instruction.
- `id_pc` output 32: head PC.
- `id_pc8` output 32: `id_pc + 8`, link value.
- `id_ready` input 1: decode accepts the head this cycle.
- `fetch_err` output 1: sticky bad-address flag. Exists only with `IFU_ADDR_CHECK_EN`; tied to 0 otherwise.

## Operation
- State:
  - Queue of DEPTH `{pc, instr}` entries, with head/tail pointers and a count.
  - In-flight register `{inflight, inflight_pc}`.
- Pop: `pop = id_valid & id_ready`.
- Issue condition: `issue = !reset & !flush & (count + inflight - pop < DEPTH)`.
- On issue:
  - `pc_en = 1`.
  - `im_addr = (pc_in - PC_BASE) >> 2`, truncated to IM_AW bits.
  - Next cycle, `inflight = 1` and `inflight_pc = pc_in`.
- On no issue: `pc_en = 0` and the in-flight register clears next cycle.
- Push: when `inflight` is set and `flush` is low, `{inflight_pc, im_rdata}` is written at the tail this cycle.
- Push and pop in the same cycle leave count unchanged; the pointers wrap modulo DEPTH.
- Flush:
  - Count goes to 0 and the pointers reset.
  - `inflight` is cleared and this cycle's returning word is discarded.
  - No issue occurs that cycle, but `pc_en = 1` is forced so the PC loads the redirect NPC.
  - Fetching resumes the next cycle from the new PC.
- Flush has priority over push, pop and issue in the same cycle.
- Outputs `id_*` are taken from the head entry. `id_valid = (count != 0)`.
- Holding stability: while `id_valid & !id_ready`, `id_*` stay stable.

## Timing
- Reset values:
  - Count 0, `inflight` 0, `id_valid` 0.
  - `id_instr` 0, `id_pc` PC_BASE, `id_pc8` PC_BASE+8.
  - `fetch_err` 0, `pc_en` 0 while `reset` is high.
- Reset mid-operation discards every queued and in-flight entry.
- Latency: a PC issued in cycle N returns `im_rdata` in N+1, is pushed at the end of N+1, and shows `id_valid` in N+2.
- Throughput: one instruction per cycle sustained with DEPTH=2 while `id_ready` stays high.
- Full queue: a stall (`id_ready = 0`) fills the queue within two cycles. After that, issue stops and `pc_en` stays 0.
- Empty queue: `id_ready` is ignored while `id_valid` is 0.
- Flush with full queue and an in-flight fetch: the cycle after the flush, `id_valid = 0`.

## Configuration
- `IFU_ADDR_CHECK_EN` defined:
  - A PC with `pc_in[1:0] != 0`, `pc_in < PC_BASE`, or `pc_in` beyond the `2^IM_AW`-word range is still issued.
  - Its pushed `instr` is forced to 32'h0 (nop).
  - `fetch_err` sets the cycle after the push and holds until `reset`.
- `IFU_ADDR_CHECK_EN` undefined:
  - No check; the address is truncated silently.
  - `fetch_err` is constant 0.

## Structure
- Shared header/package holds `PC_default` (= PC_BASE) and the nop encoding 32'h0. The header is the one already included by the PC block.
- Sub-module `ifu_queue`: a parameterised DEPTH×64-bit FIFO with push, pop, flush, count, head and full/empty outputs.
- `ifu_fetch` keeps the issue logic, in-flight tracking and address check.

## Test plan
- Reset release, `id_ready` = 1, memory word k = 32'h1000_0000+k:
  - `id_valid` rises 2 cycles after reset falls.
  - Consecutive instructions follow one per cycle with `id_pc` = 3000, 3004, 3008…
  - `id_pc8` = `id_pc + 8`.
- `id_ready` = 0 for 5 cycles mid-stream:
  - Queue holds 2 entries and `pc_en` = 0 from the 3rd stall cycle.
  - `id_*` stay constant.
  - Release continues with no gap and no duplicate.
- Flush with queue full and a fetch in flight, while the PC redirects to 32'h0000_3040:
  - Next cycle `id_valid` = 0.
  - Two cycles later, `id_pc` = 3040.
- Same-cycle push and pop at count 1 for 20 cycles: count stays 1 and the pointers wrap correctly.
- Reset asserted while 2 entries are queued: next cycle `id_valid` = 0 and `pc_en` = 0 during reset.
- With `IFU_ADDR_CHECK_EN`, `pc_in` = 32'h0000_3002:
  - The pushed `id_instr` = 0.
  - `fetch_err` goes to 1 and stays 1 until `reset`.
  - Without the macro, `fetch_err` stays 0.
